fios_modexp_sequencer: RTL
==========================

# fios_modexp_sequencer

Sequences a Montgomery modular exponentiation over the FIOS multiplier: left-to-right binary square-and-multiply on a captured exponent, including domain conversion in (×R² mod N) and out (×1). Sits above the multiplier's control FSM. Issues one start pulse per Montgomery multiplication, selects operand sources, and strobes the result into the base or accumulator register on each multiplier done. Operand storage and the multiplier itself are external.

## Interface
- EXP_WIDTH, 32, exponent width in bits (≥2).
- clock_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  request; sampled only in IDLE.
- exp_i  in  EXP_WIDTH  exponent; captured on accepted start_i.
- mm_done_i  in  1  one-cycle completion pulse from multiplier.
- mm_start_o  out  1  one-cycle start pulse to multiplier.
- mm_a_sel_o  out  2  A source: 0 accumulator, 1 base register, 2 raw base input, 3 reserved.
- mm_b_sel_o  out  2  B source: 0 accumulator, 1 base register, 2 R² mod N constant, 3 constant one.
- base_wr_en_o  out  1  write multiplier result into base register.
- acc_wr_en_o  out  1  write multiplier result into accumulator.
- acc_load_o  out  1  copy base register into accumulator.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- exp_zero_o  out  1  high with done_o when the captured exponent was 0; held until next accepted start.

## Operation
- Registers: e (EXP_WIDTH shift register), cnt ($clog2(EXP_WIDTH) bits), state.
- IDLE: if start_i, then e←exp_i and cnt←EXP_WIDTH-1. If exp_i==0, go DONE with exp_zero_o←1. Otherwise go SCAN with exp_zero_o←0.
- SCAN: one bit per cycle. If e[MSB]==0, then e←e<<1, cnt←cnt-1, stay. If e[MSB]==1, then e←e<<1 and go CI_ISSUE; cnt now equals the number of bits below the exponent MSB.
- CI_ISSUE (a_sel=2, b_sel=2, mm_start_o=1) → CI_WAIT. On mm_done_i: base_wr_en_o=1, go LOAD.
- LOAD: acc_load_o=1. If cnt==0 go OUT_ISSUE, else go SQ_ISSUE.
- SQ_ISSUE (a=0, b=0, start) → SQ_WAIT. On mm_done_i: acc_wr_en_o=1. If e[MSB]==1 go MUL_ISSUE, else go NEXT.
- MUL_ISSUE (a=0, b=1, start) → MUL_WAIT. On mm_done_i: acc_wr_en_o=1, go NEXT.
- NEXT: e←e<<1, cnt←cnt-1. If cnt==1 go OUT_ISSUE, else go SQ_ISSUE.
- OUT_ISSUE (a=0, b=3, start) → OUT_WAIT. On mm_done_i: acc_wr_en_o=1, go DONE.
- DONE: done_o=1 → IDLE.
- Select outputs hold their values through each ISSUE and WAIT pair. They are 0 in all other states.
- Multiplication count for nonzero exponent with MSB position k and popcount w: k squarings + (w-1) multiplies + 2.

## Timing
- Reset: all outputs 0, state IDLE, e and cnt cleared. Reset mid-operation aborts immediately; no further strobes are issued. An in-flight multiplier is not cancelled by this block.
- Start accepted in cycle t → busy_o=1 from t+1. exp=0: done_o at t+1.
- SCAN lasts (EXP_WIDTH-1-k)+1 cycles.
- mm_start_o is exactly one cycle, in ISSUE states only.
- mm_done_i is sampled only in WAIT states. It is ignored in all other states, including the ISSUE cycle.
- Write strobes (base_wr_en_o, acc_wr_en_o) are Mealy: asserted in the same cycle mm_done_i is seen. The state advances on the next edge.
- Per multiplication: 1 ISSUE cycle + WAIT until done, plus 1 NEXT cycle per processed exponent bit.
- start_i while busy_o=1 is ignored. start_i in the DONE cycle is ignored.
- At most one write strobe is high in any cycle. acc_load_o never coincides with a write strobe.

## Test plan
- Reset mid-MUL_WAIT with mm_done_i pulsed the same cycle → no strobe; next cycle all outputs 0, busy_o=0.
- exp_i=0 → done_o one cycle after start, exp_zero_o=1, zero mm_start_o pulses.
- exp_i=1 (EXP_WIDTH=32) → 32 SCAN cycles, then CI, LOAD, OUT. Exactly 2 mm_start_o, 1 base_wr_en_o, 1 acc_load_o, 1 acc_wr_en_o.
- exp_i=11 (0b1011), multiplier model with 5-cycle latency → op sequence CI, LOAD, SQ, SQ, MUL, SQ, MUL, OUT (7 starts). Select pairs (2,2), (0,0), (0,0), (0,1), (0,0), (0,1), (0,3).
- exp_i=0xFFFFFFFF → 64 starts (31 SQ, 31 MUL); done_o once; cnt never underflows.
- start_i held high through an operation, plus spurious mm_done_i in IDLE and ISSUE → no extra strobes. Exactly one operation runs; a new operation starts only after returning to IDLE.

Source files
------------

// File: rtl/fios_modexp_sequencer.sv
// Montgomery modular exponentiation sequencer for the FIOS multiplier.
// The exponent is scanned left to right with square-and-multiply. The base is
// first converted into the Montgomery domain (x R^2 mod N), and the result is
// converted back out at the end (x 1).
// This block issues one start pulse per multiplication, drives the operand
// selects, and strobes each result into the base register or the accumulator.
// The operand storage and the multiplier itself live outside this block.
module fios_modexp_sequencer #(
    parameter int unsigned EXP_WIDTH = 32
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [EXP_WIDTH-1:0] exp_i,
    input  logic                 mm_done_i,
    output logic                 mm_start_o,
    output logic [1:0]           mm_a_sel_o,
    output logic [1:0]           mm_b_sel_o,
    output logic                 base_wr_en_o,
    output logic                 acc_wr_en_o,
    output logic                 acc_load_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 exp_zero_o
);

    localparam int unsigned CNT_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    // Operand A sources
    localparam logic [1:0] A_ACC  = 2'd0;
    localparam logic [1:0] A_BASE = 2'd1;
    localparam logic [1:0] A_RAW  = 2'd2;

    // Operand B sources
    localparam logic [1:0] B_ACC  = 2'd0;
    localparam logic [1:0] B_BASE = 2'd1;
    localparam logic [1:0] B_R2   = 2'd2;
    localparam logic [1:0] B_ONE  = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SCAN,
        S_CI_ISSUE,
        S_CI_WAIT,
        S_LOAD,
        S_SQ_ISSUE,
        S_SQ_WAIT,
        S_MUL_ISSUE,
        S_MUL_WAIT,
        S_NEXT,
        S_OUT_ISSUE,
        S_OUT_WAIT,
        S_DONE
    } state_t;

    state_t               state;
    logic [EXP_WIDTH-1:0] e;
    logic [CNT_W-1:0]     cnt;
    logic                 e_msb;
    logic [EXP_WIDTH-1:0] e_shl;
    logic                 acc_wait;

    assign e_msb    = e[EXP_WIDTH-1];
    assign e_shl    = {e[EXP_WIDTH-2:0], 1'b0};
    assign acc_wait = (state == S_SQ_WAIT) || (state == S_MUL_WAIT) ||
                      (state == S_OUT_WAIT);

    // Result strobes follow mm_done_i in the same cycle. Reset masks them so
    // an aborted operation cannot write a register.
    assign base_wr_en_o = !reset_i && mm_done_i && (state == S_CI_WAIT);
    assign acc_wr_en_o  = !reset_i && mm_done_i && acc_wait;

    // Sequencer: the state, the exponent and counter, and the registered outputs
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state      <= S_IDLE;
            e          <= '0;
            cnt        <= '0;
            mm_start_o <= 1'b0;
            mm_a_sel_o <= '0;
            mm_b_sel_o <= '0;
            acc_load_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            exp_zero_o <= 1'b0;
        end else begin
            mm_start_o <= 1'b0;
            acc_load_o <= 1'b0;
            done_o     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        e      <= exp_i;
                        cnt    <= CNT_W'(EXP_WIDTH - 1);
                        busy_o <= 1'b1;
                        if (exp_i == '0) begin
                            state      <= S_DONE;
                            done_o     <= 1'b1;
                            exp_zero_o <= 1'b1;
                        end else begin
                            state      <= S_SCAN;
                            exp_zero_o <= 1'b0;
                        end
                    end
                end

                // Skip leading zeros. On the leading one, cnt holds the number of bits below it.
                S_SCAN: begin
                    e <= e_shl;
                    if (!e_msb) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state      <= S_CI_ISSUE;
                        mm_start_o <= 1'b1;
                        mm_a_sel_o <= A_RAW;
                        mm_b_sel_o <= B_R2;
                    end
                end

                S_CI_ISSUE: state <= S_CI_WAIT;

                S_CI_WAIT: begin
                    if (mm_done_i) begin
                        state      <= S_LOAD;
                        acc_load_o <= 1'b1;
                        mm_a_sel_o <= '0;
                        mm_b_sel_o <= '0;
                    end
                end

                // Accumulator now holds the Montgomery-domain base.
                S_LOAD: begin
                    mm_start_o <= 1'b1;
                    mm_a_sel_o <= A_ACC;
                    if (cnt == '0) begin
                        state      <= S_OUT_ISSUE;
                        mm_b_sel_o <= B_ONE;
                    end else begin
                        state      <= S_SQ_ISSUE;
                        mm_b_sel_o <= B_ACC;
                    end
                end

                S_SQ_ISSUE: state <= S_SQ_WAIT;

                S_SQ_WAIT: begin
                    if (mm_done_i) begin
                        if (e_msb) begin
                            state      <= S_MUL_ISSUE;
                            mm_start_o <= 1'b1;
                            mm_a_sel_o <= A_ACC;
                            mm_b_sel_o <= B_BASE;
                        end else begin
                            state      <= S_NEXT;
                            mm_a_sel_o <= '0;
                            mm_b_sel_o <= '0;
                        end
                    end
                end

                S_MUL_ISSUE: state <= S_MUL_WAIT;

                S_MUL_WAIT: begin
                    if (mm_done_i) begin
                        state      <= S_NEXT;
                        mm_a_sel_o <= '0;
                        mm_b_sel_o <= '0;
                    end
                end

                // Retire one exponent bit. When cnt was 1, that was the last bit.
                S_NEXT: begin
                    e          <= e_shl;
                    cnt        <= cnt - CNT_W'(1);
                    mm_start_o <= 1'b1;
                    mm_a_sel_o <= A_ACC;
                    if (cnt == CNT_W'(1)) begin
                        state      <= S_OUT_ISSUE;
                        mm_b_sel_o <= B_ONE;
                    end else begin
                        state      <= S_SQ_ISSUE;
                        mm_b_sel_o <= B_ACC;
                    end
                end

                S_OUT_ISSUE: state <= S_OUT_WAIT;

                S_OUT_WAIT: begin
                    if (mm_done_i) begin
                        state      <= S_DONE;
                        done_o     <= 1'b1;
                        mm_a_sel_o <= '0;
                        mm_b_sel_o <= '0;
                    end
                end

                S_DONE: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end

                default: begin
                    state      <= S_IDLE;
                    busy_o     <= 1'b0;
                    mm_a_sel_o <= '0;
                    mm_b_sel_o <= '0;
                end
            endcase
        end
    end

endmodule
